// File: rtl/seq_controller_if.sv
// Control/status bundle between the sequencer and the accumulator CPU datapath.
// The master side is the sequencer; the slave side is the datapath (IR, ALU, PC, memory).
interface seq_controller_if #(
  parameter int unsigned OPW = 3
) ();
  logic           ena;
  logic           zero;
  logic [OPW-1:0] opcode;
  logic           mem_rdy;
  logic           resume;
  logic           inc_pc;
  logic           load_acc;
  logic           load_pc;
  logic           rd;
  logic           wr;
  logic           load_ir;
  logic           halt;
  logic           datactr_ena;
  logic           illegal;
  logic [1:0]     ir_beat;

  modport master (
    input  ena, zero, opcode, mem_rdy, resume,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, halt, datactr_ena, illegal, ir_beat
  );

  modport slave (
    output ena, zero, opcode, mem_rdy, resume,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, halt, datactr_ena, illegal, ir_beat
  );
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU: multi-beat fetch,
// memory wait states, length-scaled skip, illegal-opcode pulse and restart from halt.
module seq_controller #(
  parameter int unsigned OPW         = 3,
  parameter int unsigned FETCH_BEATS = 2
) (
  input logic              clk,
  input logic              rst,
  seq_controller_if.master bus
);

  localparam logic [1:0] LastBeat = 2'(FETCH_BEATS - 1);
  localparam logic [1:0] SkipInit = (FETCH_BEATS >= 2) ? 2'(FETCH_BEATS - 2) : 2'd0;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StStore, StHold, StSkip, StHalted
  } state_e;

  typedef enum logic [2:0] {
    OpHlt = 3'd0, OpSkz = 3'd1, OpAdd = 3'd2, OpAnd = 3'd3,
    OpXor = 3'd4, OpLda = 3'd5, OpSto = 3'd6, OpJmp = 3'd7
  } opc_e;

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [1:0]     skip_q, skip_d;
  logic [OPW-1:0] op_q, op_d;

  opc_e op_lo, in_lo;
  logic op_bad, in_bad;

  // Only the low three bits decode; any set upper bit marks the opcode illegal.
  assign op_lo  = opc_e'(op_q[2:0]);
  assign op_bad = (op_q >> 3) != '0;
  assign in_lo  = opc_e'(bus.opcode[2:0]);
  assign in_bad = (bus.opcode >> 3) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      beat_q  <= '0;
      skip_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      skip_q  <= skip_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    skip_d  = skip_q;
    op_d    = op_q;
    if (bus.ena) begin
      case (state_q)
        StFetch: begin
          if (bus.mem_rdy) begin
            if (beat_q == LastBeat) begin
              beat_d  = '0;
              state_d = StDecode;
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end
        end
        StDecode: begin
          op_d    = bus.opcode;
          state_d = (!in_bad && in_lo == OpHlt) ? StHalted : StExec;
        end
        StExec: begin
          state_d = StFetch;
          if (!op_bad) begin
            case (op_lo)
              OpAdd, OpAnd, OpXor, OpLda: state_d = bus.mem_rdy ? StFetch : StExec;
              OpSto: state_d = StStore;
              OpSkz: begin
                if (bus.zero && FETCH_BEATS > 1) begin
                  skip_d  = SkipInit;
                  state_d = StSkip;
                end
              end
              default: state_d = StFetch;
            endcase
          end
        end
        StStore:  state_d = bus.mem_rdy ? StHold : StStore;
        StHold:   state_d = StFetch;
        StSkip: begin
          if (skip_q == '0) state_d = StFetch;
          else              skip_d  = skip_q - 2'd1;
        end
        StHalted: state_d = bus.resume ? StFetch : StHalted;
        default:  state_d = StFetch;
      endcase
    end
  end

  logic inc_pc, load_acc, load_pc, rd, wr, load_ir, halt, datactr_ena, illegal;
  logic [1:0] ir_beat;

  always_comb begin
    inc_pc      = 1'b0;
    load_acc    = 1'b0;
    load_pc     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    halt        = 1'b0;
    datactr_ena = 1'b0;
    illegal     = 1'b0;
    ir_beat     = 2'd0;
    if (bus.ena && !rst) begin
      case (state_q)
        StFetch: begin
          rd      = 1'b1;
          load_ir = 1'b1;
          ir_beat = beat_q;
          inc_pc  = bus.mem_rdy;
        end
        StExec: begin
          if (op_bad) begin
            illegal = 1'b1;
          end else begin
            case (op_lo)
              OpAdd, OpAnd, OpXor, OpLda: begin
                rd       = 1'b1;
                load_acc = bus.mem_rdy;
              end
              OpSto:   datactr_ena = 1'b1;
              OpJmp:   load_pc     = 1'b1;
              OpSkz:   inc_pc      = bus.zero;
              default: ;
            endcase
          end
        end
        StStore: begin
          wr          = 1'b1;
          datactr_ena = 1'b1;
        end
        StHold:   datactr_ena = 1'b1;
        StSkip:   inc_pc      = 1'b1;
        StHalted: halt        = 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.inc_pc      = inc_pc;
  assign bus.load_acc    = load_acc;
  assign bus.load_pc     = load_pc;
  assign bus.rd          = rd;
  assign bus.wr          = wr;
  assign bus.load_ir     = load_ir;
  assign bus.halt        = halt;
  assign bus.datactr_ena = datactr_ena;
  assign bus.illegal     = illegal;
  assign bus.ir_beat     = ir_beat;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: dut_a (OPW=4, F=2) and dut_b (OPW=3, F=3).
module tb_seq_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Packed output order: inc_pc load_acc load_pc rd wr load_ir halt datactr_ena illegal ir_beat[1:0]
  localparam logic [10:0] INC  = 11'h400;
  localparam logic [10:0] LACC = 11'h200;
  localparam logic [10:0] LPC  = 11'h100;
  localparam logic [10:0] RD   = 11'h080;
  localparam logic [10:0] WR   = 11'h040;
  localparam logic [10:0] LIR  = 11'h020;
  localparam logic [10:0] HLT  = 11'h010;
  localparam logic [10:0] DCE  = 11'h008;
  localparam logic [10:0] ILL  = 11'h004;
  localparam logic [10:0] FB0  = INC | RD | LIR;
  localparam logic [10:0] FB1  = INC | RD | LIR | 11'd1;
  localparam logic [10:0] FB2  = INC | RD | LIR | 11'd2;
  localparam logic [10:0] IDLE = 11'd0;

  seq_controller_if #(.OPW(4)) bus_a ();
  seq_controller_if #(.OPW(3)) bus_b ();

  seq_controller #(.OPW(4), .FETCH_BEATS(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_controller #(.OPW(3), .FETCH_BEATS(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  function automatic logic [10:0] outs_a();
    return {bus_a.inc_pc, bus_a.load_acc, bus_a.load_pc, bus_a.rd, bus_a.wr, bus_a.load_ir,
            bus_a.halt, bus_a.datactr_ena, bus_a.illegal, bus_a.ir_beat};
  endfunction

  function automatic logic [10:0] outs_b();
    return {bus_b.inc_pc, bus_b.load_acc, bus_b.load_pc, bus_b.rd, bus_b.wr, bus_b.load_ir,
            bus_b.halt, bus_b.datactr_ena, bus_b.illegal, bus_b.ir_beat};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.ena = 1'b1; bus_a.mem_rdy = 1'b1;
    bus_b.ena = 1'b1; bus_b.mem_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if (outs_a() !== IDLE) begin
        failures++;
        $display("FAIL reset_a cyc=%0d got=%h exp=%h", i, outs_a(), IDLE);
      end
      checks++;
      if (outs_b() !== IDLE) begin
        failures++;
        $display("FAIL reset_b cyc=%0d got=%h exp=%h", i, outs_b(), IDLE);
      end
    end
    rst = 1'b0;
    bus_a.ena = 1'b0;
    #1;
    checks++;
    if (outs_a() !== IDLE) begin
      failures++;
      $display("FAIL ena_low_outputs got=%h exp=%h", outs_a(), IDLE);
    end
    checks++;
    if (outs_b() !== FB0) begin
      failures++;
      $display("FAIL first_fetch_b got=%h exp=%h", outs_b(), FB0);
    end
  endtask

  task automatic test_skz_taken();
    logic [10:0] exp [8];
    exp = '{FB0, FB1, FB2, IDLE, INC, INC, INC, FB0};
    bus_b.ena = 1'b1; bus_b.mem_rdy = 1'b1; bus_b.zero = 1'b1; bus_b.opcode = 3'b001;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (outs_b() !== exp[i]) begin
        failures++;
        $display("FAIL skz_taken cyc=%0d got=%h exp=%h", i, outs_b(), exp[i]);
      end
      if (i != 7) next_cycle();
    end
  endtask

  task automatic test_skz_not_taken();
    logic [10:0] exp [6];
    exp = '{FB0, FB1, FB2, IDLE, IDLE, FB0};
    bus_b.zero = 1'b0; bus_b.opcode = 3'b001;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (outs_b() !== exp[i]) begin
        failures++;
        $display("FAIL skz_not_taken cyc=%0d got=%h exp=%h", i, outs_b(), exp[i]);
      end
      if (i != 5) next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    logic [10:0] exp [8];
    logic [7:0]  mr = 8'b1101_1110;
    exp = '{RD | LIR, FB0, FB1, FB2, IDLE, RD, RD | LACC, FB0};
    bus_b.opcode = 3'b101;
    for (int i = 0; i < 8; i++) begin
      bus_b.mem_rdy = mr[i];
      #1;
      checks++;
      if (outs_b() !== exp[i]) begin
        failures++;
        $display("FAIL mem_wait cyc=%0d got=%h exp=%h", i, outs_b(), exp[i]);
      end
      if (i != 7) next_cycle();
    end
    bus_b.mem_rdy = 1'b1;
    bus_b.ena = 1'b0;
  endtask

  task automatic test_lda();
    logic [10:0] exp [5];
    exp = '{FB0, FB1, IDLE, RD | LACC, FB0};
    bus_a.ena = 1'b1; bus_a.mem_rdy = 1'b1; bus_a.zero = 1'b0; bus_a.resume = 1'b0;
    bus_a.opcode = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      // The latched opcode must win over a later IR change.
      if (i == 3) bus_a.opcode = 4'b0111;
      #1;
      checks++;
      if (outs_a() !== exp[i]) begin
        failures++;
        $display("FAIL lda cyc=%0d got=%h exp=%h", i, outs_a(), exp[i]);
      end
      if (i != 4) next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp [9];
    exp = '{FB0, FB1, IDLE, LPC, FB0, FB1, IDLE, RD | LACC, FB0};
    bus_a.opcode = 4'b0111;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) bus_a.opcode = 4'b0100;
      #1;
      checks++;
      if (outs_a() !== exp[i]) begin
        failures++;
        $display("FAIL jmp_then_xor cyc=%0d got=%h exp=%h", i, outs_a(), exp[i]);
      end
      if (i != 8) next_cycle();
    end
  endtask

  task automatic test_sto();
    logic [10:0] exp [9];
    logic [8:0]  mr = 9'b1_1100_1111;
    exp = '{FB0, FB1, IDLE, DCE, WR | DCE, WR | DCE, WR | DCE, DCE, FB0};
    bus_a.opcode = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      bus_a.mem_rdy = mr[i];
      #1;
      checks++;
      if (outs_a() !== exp[i]) begin
        failures++;
        $display("FAIL sto cyc=%0d got=%h exp=%h", i, outs_a(), exp[i]);
      end
      if (i != 8) next_cycle();
    end
    bus_a.mem_rdy = 1'b1;
  endtask

  task automatic test_illegal();
    logic [10:0] exp [5];
    logic [3:0]  ops [2];
    exp = '{FB0, FB1, IDLE, ILL, FB0};
    ops = '{4'b1010, 4'b1000};
    for (int k = 0; k < 2; k++) begin
      bus_a.opcode = ops[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        checks++;
        if (outs_a() !== exp[i]) begin
          failures++;
          $display("FAIL illegal op=%b cyc=%0d got=%h exp=%h", ops[k], i, outs_a(), exp[i]);
        end
        if (i != 4) next_cycle();
      end
    end
  endtask

  task automatic test_halt();
    logic [10:0] exp [10];
    exp = '{FB0, FB1, IDLE, HLT, HLT, HLT, HLT, HLT, HLT, FB0};
    bus_a.opcode = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      bus_a.resume = (i == 8);
      #1;
      checks++;
      if (outs_a() !== exp[i]) begin
        failures++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, outs_a(), exp[i]);
      end
      if (i != 9) next_cycle();
    end
    bus_a.resume = 1'b0;
  endtask

  task automatic test_ena_rst();
    logic [10:0] exp [11];
    logic [10:0] ena_v = 11'b111_1111_0001;
    logic [10:0] rst_v = 11'b001_0000_0000;
    logic [10:0] mr_v  = 11'b110_0111_1111;
    exp = '{FB0, IDLE, IDLE, IDLE, FB1, IDLE, DCE, WR | DCE, IDLE, FB0, FB1};
    bus_a.opcode = 4'b0110;
    for (int i = 0; i < 11; i++) begin
      bus_a.ena     = ena_v[i];
      rst           = rst_v[i];
      bus_a.mem_rdy = mr_v[i];
      #1;
      checks++;
      if (outs_a() !== exp[i]) begin
        failures++;
        $display("FAIL ena_rst cyc=%0d got=%h exp=%h", i, outs_a(), exp[i]);
      end
      if (i != 10) next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    bus_a.ena = 1'b0; bus_a.zero = 1'b0; bus_a.opcode = '0; bus_a.mem_rdy = 1'b0;
    bus_a.resume = 1'b0;
    bus_b.ena = 1'b0; bus_b.zero = 1'b0; bus_b.opcode = '0; bus_b.mem_rdy = 1'b0;
    bus_b.resume = 1'b0;
    #2;
    test_reset();
    test_skz_taken();
    test_skz_not_taken();
    test_mem_wait();
    test_lda();
    test_back_to_back();
    test_sto();
    test_illegal();
    test_halt();
    test_ena_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised multi-cycle fetch/decode/execute controller for the accumulator RISC CPU. It replaces the fixed 8-phase sequencer. It adds multi-beat instruction fetch, memory wait states via `mem_rdy`, PC skip scaled to instruction length, illegal-opcode flagging, and restart from halt. It sits between the instruction register/ALU zero flag and the PC, accumulator, IR, memory and data-bus driver.

## Interface
- `OPW`, 3: opcode width (≥3); low 3 bits decoded, upper bits must be 0.
- `FETCH_BEATS`, 2: memory beats per instruction fetch, legal 1..4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `ena` in 1: advance enable; 0 freezes all state and forces all control outputs to 0.
- `zero` in 1: accumulator-zero flag, sampled in EXEC.
- `opcode` in OPW: opcode from IR, sampled in DECODE.
- `mem_rdy` in 1: memory completes current access this cycle.
- `resume` in 1: leave HALTED.
- `inc_pc`, `load_acc`, `load_pc`, `rd`, `wr`, `load_ir`, `halt`, `datactr_ena` out 1: datapath controls.
- `illegal` out 1: one-cycle pulse on illegal opcode.
- `ir_beat` out 2: IR byte lane for the current fetch beat.

## Operation
- Opcodes (low 3 bits): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. Any nonzero upper bit makes the opcode illegal.
- Registers:
  - state ∈ {FETCH, DECODE, EXEC, STORE, HOLD, SKIP, HALTED}
  - beat (2b)
  - skip_cnt (2b)
  - op (OPW, latched in DECODE; later `opcode` changes ignored)
- Outputs are a combinational decode of the registered state and the inputs. All outputs are 0 when `rst`=1 or `ena`=0. Unlisted outputs are 0.
- FETCH:
  - Drives `rd`=`load_ir`=1, `ir_beat`=beat, `inc_pc`=`mem_rdy`.
  - On `mem_rdy`: if beat=FETCH_BEATS-1, then beat←0 and go to DECODE; else beat←beat+1.
- DECODE:
  - No outputs.
  - op←`opcode`.
  - Next state: HLT → HALTED, else → EXEC.
- EXEC, behaviour by op:
  - ADD/AND/XOR/LDA: `rd`=1, `load_acc`=`mem_rdy`. Go to FETCH on `mem_rdy`, else stay.
  - STO: `datactr_ena`=1 (bus setup), then STORE.
  - JMP: `load_pc`=1, then FETCH.
  - SKZ with `zero`=1: `inc_pc`=1. If FETCH_BEATS=1 go to FETCH; else skip_cnt←FETCH_BEATS-2 and go to SKIP.
  - SKZ with `zero`=0: no outputs, then FETCH.
  - Illegal: `illegal`=1, no other outputs, then FETCH (treated as NOP).
- STORE: `wr`=`datactr_ena`=1. On `mem_rdy` go to HOLD, else stay.
- HOLD: `datactr_ena`=1 (bus hold), then FETCH.
- SKIP: `inc_pc`=1. If skip_cnt=0 go to FETCH, else skip_cnt−1.
- HALTED: `halt`=1. On `resume` go to FETCH; `resume` is ignored in every other state.
- Reset: state←FETCH, beat←0, skip_cnt←0, op←0. The first access after `rst` falls is the fetch of beat 0.

## Timing
- All transitions happen on the rising `clk` edge and only when `ena`=1.
- Latency with `mem_rdy` tied 1 and FETCH_BEATS=F:
  - ALU/LDA/JMP/illegal/SKZ not taken: F+2 cycles.
  - SKZ taken: 2F+1 cycles.
  - STO: F+4 cycles.
  - HLT: F+1 cycles to HALTED.
- Each cycle with `mem_rdy`=0 in FETCH, EXEC (memory ops) or STORE adds one cycle. While waiting, outputs hold, except `inc_pc` and `load_acc`, which are 0.
- `wr` is never asserted without `datactr_ena` in the same cycle. `datactr_ena` is high one cycle before and one cycle after the `wr` window.
- Exactly one `inc_pc` per fetch beat, plus F on a taken skip.
- `ena` low mid-instruction: state, beat and skip_cnt freeze and outputs go 0. Execution resumes in the same state when `ena` returns.
- `rst` mid-STORE/SKIP/HALTED: outputs drop in the same cycle and the next state is FETCH with beat 0. No partial skip count survives.

## Test plan
- Reset, F=2, `mem_rdy`=1, opcode=LDA: cycles 0–1 `rd`=`load_ir`=`inc_pc`=1 with `ir_beat`=0,1; cycle 2 idle; cycle 3 `rd`=`load_acc`=1; cycle 4 back in FETCH.
- STO, F=2, `mem_rdy` low for 2 cycles in STORE: EXEC `datactr_ena` only; 3 cycles `wr`=`datactr_ena`=1; then 1 HOLD cycle with `datactr_ena`=1; total 8 cycles.
- SKZ, F=3, `zero`=1: `inc_pc` high 3 fetch cycles + 3 skip cycles; `zero`=0 gives no extra `inc_pc`.
- HLT, then `resume` pulse after 5 cycles: `halt`=1 from cycle F+1 until the `resume` edge; the next cycle is FETCH beat 0 with `halt`=0.
- OPW=4, opcode=4'b1010: `illegal`=1 for exactly one cycle in EXEC, no other outputs, next instruction fetched.
- `ena`=0 for 3 cycles mid-FETCH beat 1, then `rst` asserted during STORE: outputs 0 while frozen; beat 1 resumes; after reset, `wr`=0 in the same cycle and FETCH beat 0 follows.
